// File: rtl/aes_pkg.sv
// Shared AES round-stage definitions: state geometry, forward S-box table and FSM encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTES   = 16;

    // FIPS-197 forward S-box, indexed by input byte.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Common encoding for the iterative round stages.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_stage_state_e;

endpackage

// File: rtl/sub_bytes_seq_if.sv
// Handshake bundle for sub_bytes_seq: input state channel, output state channel, busy flag.
// Latency: n/a (wires only).
// Backpressure: in_ready / out_ready carry flow control; slave = the substitution block.
interface sub_bytes_seq_if;
    import aes_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_STATE_W-1:0] state_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_STATE_W-1:0] state_out;
    logic                   busy;

    modport slave (
        input  in_valid, state_in, out_ready,
        output in_ready, out_valid, state_out, busy
    );

    modport master (
        output in_valid, state_in, out_ready,
        input  in_ready, out_valid, state_out, busy
    );

endinterface

// File: rtl/aes_sbox.sv
// Single forward AES S-box lookup (din -> SBOX[din]).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of din.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = SBOX[din];

endmodule

// File: rtl/sub_bytes_seq.sv
// Iterative AES SubBytes: BYTES_PER_CYCLE shared S-boxes walk the 16-byte state, byte 0 first.
// Latency: 16/BYTES_PER_CYCLE cycles from input handshake to out_valid; II = latency + 1.
// Backpressure: result held in DONE until out_ready; in_ready = out_ready in DONE (comb path).
// Ports: clk, rst (sync, active-high); bus = in_valid/in_ready/state_in,
//        out_valid/out_ready/state_out, busy (high while substituting).
module sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic             clk,
    input  logic             rst,
    sub_bytes_seq_if.slave   bus
);

    localparam int N_CYC = AES_BYTES / BYTES_PER_CYCLE;
    localparam int CNT_W = (N_CYC > 1) ? $clog2(N_CYC) : 1;

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
        $error("sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    aes_stage_state_e       state;
    logic [CNT_W-1:0]       cnt;
    logic [AES_STATE_W-1:0] work_reg;
    logic                   out_valid_q;
    logic                   busy_q;

    logic [7:0]             wb       [AES_BYTES];
    logic [3:0]             lane_idx [BYTES_PER_CYCLE];
    logic [7:0]             sb_in    [BYTES_PER_CYCLE];
    logic [7:0]             sb_out   [BYTES_PER_CYCLE];
    logic [AES_STATE_W-1:0] sub_state;

    // Byte view of work_reg; byte 0 sits in the top bits.
    always_comb begin
        for (int i = 0; i < AES_BYTES; i++) begin
            wb[i] = work_reg[AES_STATE_W-1-8*i -: 8];
        end
    end

    // Lane l handles byte cnt*B + l this cycle.
    for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_lane
        assign lane_idx[l] = 4'(32'(cnt) * BYTES_PER_CYCLE + l);
        assign sb_in[l]    = wb[lane_idx[l]];

        aes_sbox u_sbox (
            .din  (sb_in[l]),
            .dout (sb_out[l])
        );
    end

    // Next work_reg in RUN: only the lanes selected by cnt change.
    always_comb begin
        sub_state = work_reg;
        for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
            sub_state[AES_STATE_W-1-8*int'(lane_idx[l]) -: 8] = sb_out[l];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            work_reg    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        work_reg <= bus.state_in;
                        cnt      <= '0;
                        busy_q   <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    work_reg <= sub_state;
                    if (cnt == CNT_W'(N_CYC - 1)) begin
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        // Capture alongside the output transfer to hit the minimum II.
                        if (bus.in_valid) begin
                            work_reg <= bus.state_in;
                            cnt      <= '0;
                            busy_q   <= 1'b1;
                            state    <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Ready is the only combinational output: it follows out_ready in DONE.
    always_comb begin
        bus.in_ready = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE:    bus.in_ready = 1'b1;
                DONE:    bus.in_ready = bus.out_ready;
                default: bus.in_ready = 1'b0;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.state_out = work_reg;

endmodule
